branch_pc_unit: RTL and testbench
=================================

# branch_pc_unit

Program-counter register and conditional-branch sequencer that consumes the registered branch-condition flag (CONout) produced by the CON flip-flop stage. Holds the 32-bit PC, handles fetch increment and direct bus loads, and on a branch request samples the condition flag, adds the sign-extended IR offset when the branch is taken, and signals completion. It sits between the CON stage and the PC/MAR path feeding instruction fetch.

## Interface
- WIDTH, 32, PC and bus width
- OFFSET_W, 19, width of the IR branch displacement field (C2)
- RESET_PC, 32'h0, PC value loaded on reset
- clk  input  1  system clock, all state updates on rising edge
- clear  input  1  reset, synchronous, active-high
- inc_pc  input  1  fetch increment request, PC <= PC + 1
- pc_in  input  1  load PC from bus_in (JR/JAL/direct load)
- bus_in  input  WIDTH  BusMuxOut value for pc_in loads
- br_start  input  1  start branch sequence (one-cycle pulse)
- br_offset  input  OFFSET_W  IR displacement, two's complement
- con_flag  input  1  CONout from the condition flip-flop
- pc_out  output  WIDTH  current PC
- busy  output  1  high whenever FSM not IDLE
- done  output  1  one-cycle completion strobe
- taken  output  1  result of most recent branch evaluation

## Operation
- States: IDLE, EVAL, ADD, DONE; state register reset to IDLE.
- IDLE: br_start=1 -> EVAL. Otherwise stay.
- EVAL: taken <= con_flag; -> ADD. (CONin edge precedes br_start by at least one cycle; con_flag is stable here.)
- ADD: if taken, PC <= PC + sign_extend(br_offset); -> DONE. Not taken: PC unchanged.
- DONE: -> IDLE unconditionally.
- busy = (state != IDLE); done = (state == DONE); both decoded from state register.
- Priority each edge: clear > pc_in > branch-ADD update > inc_pc.
- pc_in while busy: PC <= bus_in, FSM aborts to IDLE, no done strobe, taken keeps its last value.
- inc_pc ignored while busy; br_start ignored while busy.
- Arithmetic: br_offset sign-extended to WIDTH; all PC adds modulo 2^WIDTH (PC=32'hFFFFFFFF + 1 -> 0).
- Reset values: pc_out=RESET_PC, busy=0, done=0, taken=0.

## Timing
- br_start sampled at edge n -> EVAL after n; taken valid after n+1; PC updated and done=1 after n+2; IDLE after n+3. Branch latency: 3 cycles, next br_start accepted at edge n+3.
- inc_pc / pc_in: PC updated at the sampling edge, visible on pc_out the following cycle.
- clear asserted mid-sequence: at that edge everything returns to reset values; no done.
- clear and pc_in simultaneous: clear wins.
- br_start and pc_in in the same IDLE cycle: PC loaded from bus_in, branch does not start.
- br_start and inc_pc in the same IDLE cycle: PC increments and FSM enters EVAL; the subsequent add uses the incremented PC.

## Configuration
- BR_COUNT_EN defined: adds output br_count [7:0]; increments at the ADD edge when taken=1, saturates at 8'hFF, cleared to 0 by clear, unaffected by aborts occurring before ADD.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset: assert clear one cycle -> pc_out=0, busy=0, done=0, taken=0.
- Increment wrap: pc_in with bus_in=32'hFFFFFFFF, then inc_pc -> pc_out=32'h0.
- Taken forward: PC=32'h10, con_flag=1, br_start, br_offset=19'h00005 -> taken=1, done at cycle 3, pc_out=32'h15.
- Taken backward / not taken: PC=32'h20, offset=19'h7FFFC, con_flag=1 -> pc_out=32'h1C; repeat with con_flag=0 -> pc_out stays 32'h20, taken=0, done still pulses.
- Abort: br_start, then pc_in with bus_in=32'h100 during EVAL -> pc_out=32'h100, busy=0 next cycle, no done; inc_pc during busy has no effect.
- BR_COUNT_EN: 300 taken branches -> br_count=8'hFF; clear -> 8'h00.

Source files
------------

// File: rtl/branch_pc_unit.sv
// PC register with a four-state conditional-branch sequencer fed by the CON flag.
// Optional BR_COUNT_EN adds a saturating taken-branch counter output br_count.
module branch_pc_unit #(
   parameter int               WIDTH    = 32,
   parameter int               OFFSET_W = 19,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                clear,
   input  logic                inc_pc,
   input  logic                pc_in,
   input  logic [WIDTH-1:0]    bus_in,
   input  logic                br_start,
   input  logic [OFFSET_W-1:0] br_offset,
   input  logic                con_flag,
   output logic [WIDTH-1:0]    pc_out,
   output logic                busy,
   output logic                done,
   output logic                taken
`ifdef BR_COUNT_EN
   ,
   output logic [7:0]          br_count
`endif
);

   typedef enum logic [1:0] {IDLE, EVAL, ADD, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] pc_q, pc_nxt;
   logic             taken_q, taken_nxt;
   logic [WIDTH-1:0] offset_ext;

   assign offset_ext = {{(WIDTH-OFFSET_W){br_offset[OFFSET_W-1]}}, br_offset};

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      taken_nxt = taken_q;
      case (state)
         IDLE: if (br_start) state_nxt = EVAL;
         EVAL: begin
            taken_nxt = con_flag;
            state_nxt = ADD;
         end
         ADD: begin
            if (taken_q) pc_nxt = pc_q + offset_ext;
            state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
      // increments only between branches, so never competes with the ADD update
      if (state == IDLE && inc_pc) pc_nxt = pc_q + WIDTH'(1);
      // bus load overrides everything and aborts a branch in flight
      if (pc_in) begin
         pc_nxt    = bus_in;
         state_nxt = IDLE;
         taken_nxt = taken_q;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state   <= IDLE;
         pc_q    <= RESET_PC;
         taken_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc_q    <= pc_nxt;
         taken_q <= taken_nxt;
      end
   end

`ifdef BR_COUNT_EN
   logic [7:0] cnt_q;
   always_ff @(posedge clk) begin
      if (clear)
         cnt_q <= '0;
      else if (state == ADD && taken_q && !pc_in && cnt_q != 8'hFF)
         cnt_q <= cnt_q + 8'd1;
   end
   assign br_count = cnt_q;
`endif

   assign pc_out = pc_q;
   assign taken  = taken_q;
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed plus randomized transaction-level checks of branch_pc_unit against a PC/taken model.
module tb_branch_pc_unit;

   logic        clk = 0;
   logic        clear = 0, inc_pc = 0, pc_in = 0, br_start = 0, con_flag = 0;
   logic [31:0] bus_in = 0;
   logic [18:0] br_offset = 0;
   logic [31:0] pc_out;
   logic        busy, done, taken;
`ifdef BR_COUNT_EN
   logic [7:0]  br_count;
`endif

   int checks = 0, errors = 0;
   logic [31:0] m_pc = 0;
   logic        m_taken = 0;
   int          m_cnt = 0;

   branch_pc_unit dut (
      .clk(clk), .clear(clear), .inc_pc(inc_pc), .pc_in(pc_in), .bus_in(bus_in),
      .br_start(br_start), .br_offset(br_offset), .con_flag(con_flag),
      .pc_out(pc_out), .busy(busy), .done(done), .taken(taken)
`ifdef BR_COUNT_EN
      , .br_count(br_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic exp_busy, input logic exp_done);
      check({tag, ".pc"}, pc_out, m_pc);
      check({tag, ".busy"}, {31'd0, busy}, {31'd0, exp_busy});
      check({tag, ".done"}, {31'd0, done}, {31'd0, exp_done});
      check({tag, ".taken"}, {31'd0, taken}, {31'd0, m_taken});
`ifdef BR_COUNT_EN
      check({tag, ".cnt"}, {24'd0, br_count}, m_cnt);
`endif
   endtask

   function automatic logic [31:0] sext(input logic [18:0] off);
      int v;
      v = off[18] ? int'(off) - (1 << 19) : int'(off);
      return 32'(v);
   endfunction

   task automatic do_clear();
      clear = 1; tick(); clear = 0;
      m_pc = 0; m_taken = 0; m_cnt = 0;
      check_all("clear", 0, 0);
   endtask

   task automatic do_inc();
      inc_pc = 1; tick(); inc_pc = 0;
      m_pc = m_pc + 1;
      check_all("inc", 0, 0);
   endtask

   task automatic do_load(input logic [31:0] v);
      pc_in = 1; bus_in = v; tick(); pc_in = 0;
      m_pc = v;
      check_all("load", 0, 0);
   endtask

   // full branch; inc_pc is toggled randomly while busy and must be ignored
   task automatic do_branch(input logic [18:0] off, input logic flag, input logic with_inc);
      con_flag = flag; br_offset = off; br_start = 1; inc_pc = with_inc;
      tick(); br_start = 0;
      if (with_inc) m_pc = m_pc + 1;
      inc_pc = 1'($urandom);
      check_all("br_eval", 1, 0);
      tick(); inc_pc = 1'($urandom);
      m_taken = flag;
      check_all("br_add", 1, 0);
      tick(); inc_pc = 1'($urandom);
      if (flag) begin
         m_pc = m_pc + sext(off);
         if (m_cnt < 255) m_cnt++;
      end
      check_all("br_done", 1, 1);
      tick(); inc_pc = 0;
      check_all("br_idle", 0, 0);
   endtask

   // abort with pc_in while in EVAL (at=0) or ADD (at=1)
   task automatic do_abort(input logic [18:0] off, input logic flag, input int at,
                           input logic [31:0] v);
      con_flag = flag; br_offset = off; br_start = 1;
      tick(); br_start = 0;
      if (at == 1) begin
         tick();
         m_taken = flag;
      end
      pc_in = 1; bus_in = v; tick(); pc_in = 0;
      m_pc = v;
      check_all("abort", 0, 0);
      tick();
      check_all("abort_after", 0, 0);
   endtask

   initial begin
      logic [18:0] off;
      logic [31:0] v;
      int          op;

      do_clear();
      // increment wrap
      do_load(32'hFFFF_FFFF);
      do_inc();
      check("wrap", pc_out, 32'h0);
      // forward taken
      do_load(32'h10);
      do_branch(19'h00005, 1, 0);
      check("fwd", pc_out, 32'h15);
      // backward taken / not taken
      do_load(32'h20);
      do_branch(19'h7FFFC, 1, 0);
      check("bwd", pc_out, 32'h1C);
      do_load(32'h20);
      do_branch(19'h7FFFC, 0, 0);
      check("nt", pc_out, 32'h20);
      // abort in EVAL and ADD
      do_abort(19'h00040, 1, 0, 32'h100);
      check("abort_pc", pc_out, 32'h100);
      do_abort(19'h00040, 1, 1, 32'h200);
      // br_start with inc_pc: add uses incremented PC
      do_load(32'h30);
      do_branch(19'h00010, 1, 1);
      check("inc_br", pc_out, 32'h41);
      // br_start with pc_in: load wins, no branch
      br_start = 1; pc_in = 1; bus_in = 32'h55; con_flag = 1;
      tick(); br_start = 0; pc_in = 0;
      m_pc = 32'h55;
      check_all("br_vs_load", 0, 0);
      // clear beats pc_in
      clear = 1; pc_in = 1; bus_in = 32'hABCD; tick(); clear = 0; pc_in = 0;
      m_pc = 0; m_taken = 0; m_cnt = 0;
      check_all("clr_vs_load", 0, 0);
      // clear mid-branch
      do_load(32'h77);
      con_flag = 1; br_offset = 19'h1; br_start = 1; tick(); br_start = 0;
      tick(); clear = 1; tick(); clear = 0;
      m_pc = 0; m_taken = 0; m_cnt = 0;
      check_all("clr_mid", 0, 0);
      tick();
      check_all("clr_mid_after", 0, 0);

      // randomized transactions
      for (int i = 0; i < 300; i++) begin
         op  = $urandom_range(0, 9);
         off = 19'($urandom);
         v   = $urandom;
         case (op)
            0:       do_clear();
            1, 2:    do_inc();
            3:       do_load(v);
            4:       do_abort(off, 1'($urandom), $urandom_range(0, 1), v);
            default: do_branch(off, 1'($urandom), 1'($urandom));
         endcase
      end

`ifdef BR_COUNT_EN
      do_clear();
      for (int i = 0; i < 300; i++) do_branch(19'h1, 1, 0);
      check("cnt_sat", {24'd0, br_count}, 32'hFF);
      do_clear();
      check("cnt_clr", {24'd0, br_count}, 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
